// File: rtl/ripple_count_capture.sv
// ripple_count_capture: resynchronises an asynchronous ripple-counter value, accumulates settled
// increments per WINDOW-cycle window and presents each window total on a valid/ready output.
// Define RIPPLE_CAP_ALARM_EN to add the registered `alarm` output (result >= ALARM_LEVEL).
module ripple_count_capture #(
    parameter int unsigned CW          = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TW          = 16,
    parameter int unsigned WINDOW      = 32,
    parameter int          ALARM_LEVEL = 100
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] q_in,
    input  logic          en,
    output logic [TW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          overrun,
    input  logic          ovr_clr
`ifdef RIPPLE_CAP_ALARM_EN
    ,
    output logic          alarm
`endif
);

    localparam int unsigned WCW = $clog2(WINDOW);
    localparam logic [WCW-1:0] WLAST = WCW'(WINDOW - 1);

    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("ripple_count_capture: SYNC_STAGES must be >= 2");
    end
    if (WINDOW < 2) begin : g_chk_window
        $error("ripple_count_capture: WINDOW must be >= 2");
    end
    if (TW < CW) begin : g_chk_tw
        $error("ripple_count_capture: TW must be >= CW");
    end
    if (ALARM_LEVEL < 0) begin : g_chk_alarm
        $error("ripple_count_capture: ALARM_LEVEL must be non-negative");
    end

    typedef enum logic {
        ARM,
        RUN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] sync_q [SYNC_STAGES];
    logic [CW-1:0] s;
    logic [CW-1:0] s_prev;
    logic [CW-1:0] base_q, base_d;
    logic [TW-1:0] acc_q, acc_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;

    logic          stable;
    logic [CW-1:0] delta;
    logic [TW:0]   sum;
    logic [TW-1:0] result;
    logic          close;
    logic          load;
    logic          xfer;
    logic [TW-1:0] out_data_d;
    logic          out_valid_d;
    logic          overrun_d;

    // Resynchroniser; s_prev lets a sample be accepted only once it has held for a full cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            s_prev <= '0;
        end else begin
            sync_q[0] <= q_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            s_prev <= s;
        end
    end

    assign s      = sync_q[SYNC_STAGES-1];
    assign stable = (s == s_prev);

    always_comb begin
        delta  = stable ? (s - base_q) : '0;
        sum    = {1'b0, acc_q} + (TW+1)'(delta);
        result = sum[TW] ? '1 : sum[TW-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARM;
            base_q  <= '0;
            acc_q   <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            acc_q   <= acc_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        acc_d   = acc_q;
        wcnt_d  = wcnt_q;
        close   = 1'b0;
        case (state_q)
            ARM: begin
                acc_d  = '0;
                wcnt_d = '0;
                if (stable && en) begin
                    base_d  = s;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    // Dropping enable abandons the partial window; output side is untouched.
                    state_d = ARM;
                    acc_d   = '0;
                    wcnt_d  = '0;
                end else begin
                    if (stable) begin
                        base_d = s;
                    end
                    if (wcnt_q == WLAST) begin
                        close  = 1'b1;
                        acc_d  = '0;
                        wcnt_d = '0;
                    end else begin
                        acc_d  = result;
                        wcnt_d = wcnt_q + WCW'(1);
                    end
                end
            end
            default: state_d = ARM;
        endcase
    end

    always_comb begin
        xfer        = out_valid && out_ready;
        load        = close && (!out_valid || out_ready);
        out_data_d  = out_data;
        out_valid_d = out_valid;
        overrun_d   = overrun;
        if (load) begin
            out_data_d  = result;
            out_valid_d = 1'b1;
        end else if (xfer) begin
            out_valid_d = 1'b0;
        end
        // A result dropped in the same cycle as a clear request keeps the flag set.
        if (close && !load) begin
            overrun_d = 1'b1;
        end else if (ovr_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_data  <= out_data_d;
            out_valid <= out_valid_d;
            overrun   <= overrun_d;
        end
    end

`ifdef RIPPLE_CAP_ALARM_EN
    localparam bit ALARM_REACH = (longint'(ALARM_LEVEL) < (longint'(1) << TW));
    localparam logic [TW-1:0] ALARM_THR = ALARM_REACH ? TW'(ALARM_LEVEL) : '1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alarm <= 1'b0;
        end else if (load) begin
            alarm <= ALARM_REACH && (result >= ALARM_THR);
        end
    end
`endif

endmodule

// File: tb/tb_ripple_count_capture.sv
// Bench for ripple_count_capture: a 16-bit and a 4-bit (saturating, ALARM_LEVEL=6) instance share
// stimulus; window totals go into scoreboards and are checked when each output transfer occurs.
module tb_ripple_count_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  q_in = '0;
    logic        en = 1'b0;
    logic        out_ready = 1'b0;
    logic        ovr_clr = 1'b0;
    logic [15:0] out_data;
    logic        out_valid, overrun;
    logic [3:0]  out_data4;
    logic        out_valid4, overrun4;
`ifdef RIPPLE_CAP_ALARM_EN
    logic        alarm, alarm4;
`endif

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int unsigned sb_a[$];
    int unsigned sb_b[$];
    int unsigned wt = 0;
    int unsigned exp_sum = 0;

    always #5 clk = ~clk;

    ripple_count_capture #(
        .CW(4), .SYNC_STAGES(2), .TW(16), .WINDOW(32), .ALARM_LEVEL(100)
    ) dut (
        .clk(clk), .reset(reset), .q_in(q_in), .en(en),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .overrun(overrun), .ovr_clr(ovr_clr)
`ifdef RIPPLE_CAP_ALARM_EN
        , .alarm(alarm)
`endif
    );

    ripple_count_capture #(
        .CW(4), .SYNC_STAGES(2), .TW(4), .WINDOW(32), .ALARM_LEVEL(6)
    ) dut4 (
        .clk(clk), .reset(reset), .q_in(q_in), .en(en),
        .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready),
        .overrun(overrun4), .ovr_clr(ovr_clr)
`ifdef RIPPLE_CAP_ALARM_EN
        , .alarm(alarm4)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
        return (v > mx) ? mx : v;
    endfunction

    // Output monitor: a transfer happens at the next rising edge when valid and ready are both high.
    always begin
        @(negedge clk);
        #1;
        if (reset) begin
            if (out_valid && out_ready) begin
                if (sb_a.size() == 0) begin
                    check("spurious_valid", out_valid, 0);
                end else begin
                    int unsigned e;
                    e = sb_a.pop_front();
                    check("out_data", out_data, sat(e, 65535));
`ifdef RIPPLE_CAP_ALARM_EN
                    check("alarm", alarm, 32'(sat(e, 65535) >= 100));
`endif
                end
            end
            if (out_valid4 && out_ready) begin
                if (sb_b.size() == 0) begin
                    check("spurious_valid4", out_valid4, 0);
                end else begin
                    int unsigned e;
                    e = sb_b.pop_front();
                    check("out_data4", out_data4, sat(e, 15));
`ifdef RIPPLE_CAP_ALARM_EN
                    check("alarm4", alarm4, 32'(sat(e, 15) >= 6));
`endif
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        wt++;
    endtask

    task automatic wait_to(input int unsigned t);
        while (wt < t) tick();
    endtask

    task automatic step_to(input logic [3:0] v);
        logic [3:0] d;
        d = v - q_in;
        exp_sum += d;
        q_in = v;
    endtask

    // Changes at window-local t <= 28 settle into the same window's total.
    task automatic steps(input int unsigned n, input int unsigned t0, input int unsigned gap,
                         input logic [3:0] inc);
        for (int unsigned i = 0; i < n; i++) begin
            wait_to(t0 + i * gap);
            step_to(q_in + inc);
        end
    endtask

    task automatic arm();
        en = 1'b0;
        repeat (6) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        wt = 0;
        exp_sum = 0;
    endtask

    task automatic win_end(input bit loaded);
        wait_to(32);
        if (loaded) begin
            sb_a.push_back(exp_sum);
            sb_b.push_back(exp_sum);
        end
        wt = 0;
        exp_sum = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #23 reset = 1'b1;

        // Held result, then asynchronous reset between clock edges
        arm();
        out_ready = 1'b0;
        steps(5, 0, 4, 4'd1);
        win_end(1'b0);
        check("pre_reset_valid", out_valid, 1);
        check("pre_reset_data", out_data, 5);
        wait_to(15);
        #2 reset = 1'b0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_overrun", overrun, 0);
        check("rst_valid4", out_valid4, 0);
        check("rst_data4", out_data4, 0);
`ifdef RIPPLE_CAP_ALARM_EN
        check("rst_alarm", alarm, 0);
        check("rst_alarm4", alarm4, 0);
`endif
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // First window after reset closes exactly WINDOW cycles after ARM exit
        out_ready = 1'b1;
        arm();
        steps(8, 0, 4, 4'd1);
        wait_to(31);
        check("pre_close_valid", out_valid, 0);
        win_end(1'b1);
        check("first_close_valid", out_valid, 1);

        // Steady counting: +1 every 4 cycles gives 8 per window
        for (int unsigned w = 0; w < 2; w++) begin
            steps(8, 0, 4, 4'd1);
            win_end(1'b1);
        end

        // Small total (alarm falls back after the previous 8)
        steps(3, 0, 5, 4'd1);
        win_end(1'b1);

        // Wrap: reach 14, then jump to 2 in the next window
        wait_to(2);
        step_to(4'd14);
        win_end(1'b1);
        wait_to(4);
        step_to(4'd2);
        win_end(1'b1);

        // Glitch for one cycle is ignored; a value held two cycles is counted once
        wait_to(2);
        q_in = q_in + 4'd3;
        tick();
        q_in = q_in - 4'd3;
        wait_to(10);
        step_to(q_in + 4'd5);
        wait_to(12);
        step_to(q_in + 4'd2);
        win_end(1'b1);

        // 20 events: saturates to 15 on the 4-bit instance
        steps(4, 0, 4, 4'd5);
        win_end(1'b1);

        // Backpressure across two closes
        wait_to(2);
        out_ready = 1'b0;
        steps(3, 4, 4, 4'd1);
        win_end(1'b1);
        steps(8, 0, 3, 4'd1);
        win_end(1'b0);
        check("ovr_set", overrun, 1);
        check("ovr_set4", overrun4, 1);
        check("held_valid", out_valid, 1);
        check("held_data", out_data, sb_a[0]);
        check("held_data4", out_data4, sat(sb_b[0], 15));
`ifdef RIPPLE_CAP_ALARM_EN
        check("alarm4_after_drop", alarm4, 0);
`endif
        en = 1'b0;
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("ovr_clr", overrun, 0);
        check("ovr_clr4", overrun4, 0);
        check("held_valid_after_clr", out_valid, 1);
        out_ready = 1'b1;
        tick();
        tick();
        check("valid_after_xfer", out_valid, 0);
        check("valid_after_xfer4", out_valid4, 0);

        // Dropping enable mid-window discards the partial count
        arm();
        steps(1, 0, 1, 4'd2);
        wait_to(10);
        en = 1'b0;
        arm();
        steps(1, 0, 1, 4'd1);
        win_end(1'b1);

        repeat (4) @(negedge clk);
        check("sb_drain", sb_a.size(), 0);
        check("sb_drain4", sb_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
